// File: rtl/comma_aligner_if.sv
// Bundle of the serial-in / aligned-word-out signals of comma_aligner.
// master drives the serial line and consumes words; slave is the aligner side.
interface comma_aligner_if;
    logic       i_Bit_Valid;
    logic       i_Bit;
    logic [9:0] o_Word;
    logic       o_Word_Valid;
    logic       o_Comma;
    logic       o_Code_Err;
    logic       o_Locked;
    logic [7:0] o_Err_Count;

    modport master (
        output i_Bit_Valid, i_Bit,
        input  o_Word, o_Word_Valid, o_Comma, o_Code_Err, o_Locked, o_Err_Count
    );

    modport slave (
        input  i_Bit_Valid, i_Bit,
        output o_Word, o_Word_Valid, o_Comma, o_Code_Err, o_Locked, o_Err_Count
    );
endinterface

// File: rtl/comma_aligner.sv
// K28.5 comma aligner for a serial 8b/10b stream: hunts for a comma, then slices 10-bit words.
// Optional saturating code-error counter enabled by macro COMMA_ALIGNER_ERR_CNT_EN.
module comma_aligner #(
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Bit_Valid,
    input  logic       i_Bit,
    output logic [9:0] o_Word,
    output logic       o_Word_Valid,
    output logic       o_Comma,
    output logic       o_Code_Err,
    output logic       o_Locked,
    output logic [7:0] o_Err_Count
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [3:0] LP_LIMIT = 4'(ERR_LIMIT);

    state_t     r_state, w_state_next;
    logic [9:0] r_sr;
    logic [3:0] r_bit_cnt, w_bit_cnt_next;
    logic [3:0] r_err_run, w_err_run_next;
    logic [9:0] w_window;
    logic [3:0] w_ones;
    logic       w_is_comma;
    logic       w_invalid;
    logic       w_emit;

    assign w_window   = {i_Bit, r_sr[9:1]};
    assign w_is_comma = (w_window == 10'b0011111010) || (w_window == 10'b1100000101);

    always_comb begin
        w_ones = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'b000, w_window[i]};
        end
    end

    assign w_invalid = !w_is_comma && ((w_ones < 4'd4) || (w_ones > 4'd6));

    // State register plus the registered datapath and outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state      <= HUNT;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_err_run    <= '0;
            o_Word       <= '0;
            o_Word_Valid <= 1'b0;
            o_Comma      <= 1'b0;
            o_Code_Err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_err_run    <= w_err_run_next;
            o_Word_Valid <= w_emit;
            o_Comma      <= w_emit && w_is_comma;
            o_Code_Err   <= w_emit && w_invalid;
            if (i_Bit_Valid) begin
                r_sr <= w_window;
            end
            if (w_emit) begin
                o_Word <= w_window;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_err_run_next = r_err_run;
        if (i_Bit_Valid) begin
            case (r_state)
                HUNT: begin
                    if (w_is_comma) begin
                        w_state_next   = LOCKED;
                        w_bit_cnt_next = '0;
                        w_err_run_next = '0;
                    end
                end
                LOCKED: begin
                    if (r_bit_cnt == 4'd9) begin
                        w_bit_cnt_next = '0;
                        if (!w_invalid) begin
                            w_err_run_next = '0;
                        end else if (r_err_run + 4'd1 == LP_LIMIT) begin
                            w_state_next   = HUNT;
                            w_err_run_next = '0;
                        end else begin
                            w_err_run_next = r_err_run + 4'd1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        w_emit = 1'b0;
        if (i_Bit_Valid) begin
            case (r_state)
                HUNT:    w_emit = w_is_comma;
                LOCKED:  w_emit = (r_bit_cnt == 4'd9);
                default: w_emit = 1'b0;
            endcase
        end
    end

    assign o_Locked = (r_state == LOCKED);

`ifdef COMMA_ALIGNER_ERR_CNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_err_count <= '0;
        end else if (o_Code_Err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_Err_Count = r_err_count;
`else
    assign o_Err_Count = '0;
`endif

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: expected word pulses are queued as bits are driven
// and checked by a negedge monitor; level checks are made from the stimulus sequence.
module tb_comma_aligner;

    typedef struct {
        logic [9:0] word;
        logic       comma;
        logic       err;
        logic       locked;
    } exp_t;

    logic   clk;
    logic   rst;
    int     errors;
    int     checks;
    exp_t   q[$];

    comma_aligner_if u_if ();

    comma_aligner #(.ERR_LIMIT(4)) u_dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Bit_Valid  (u_if.i_Bit_Valid),
        .i_Bit        (u_if.i_Bit),
        .o_Word       (u_if.o_Word),
        .o_Word_Valid (u_if.o_Word_Valid),
        .o_Comma      (u_if.o_Comma),
        .o_Code_Err   (u_if.o_Code_Err),
        .o_Locked     (u_if.o_Locked),
        .o_Err_Count  (u_if.o_Err_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] w, input logic c, input logic e, input logic l);
        exp_t x;
        x.word = w; x.comma = c; x.err = e; x.locked = l;
        q.push_back(x);
    endtask

    task automatic send_bit(input logic b);
        u_if.i_Bit_Valid = 1'b1;
        u_if.i_Bit       = b;
        @(posedge clk); #1;
        u_if.i_Bit_Valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic send_word_toggle(input logic [9:0] w);
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i]);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 10'(q.size()), 10'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.o_Word_Valid) begin
                chk("pulse_expected", 10'(q.size() != 0), 10'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word",   u_if.o_Word,            e.word);
                    chk("comma",  10'(u_if.o_Comma),      10'(e.comma));
                    chk("code_err", 10'(u_if.o_Code_Err), 10'(e.err));
                    chk("locked_at_pulse", 10'(u_if.o_Locked), 10'(e.locked));
                end
            end else if (u_if.o_Comma || u_if.o_Code_Err) begin
                chk("flags_idle", {8'd0, u_if.o_Comma, u_if.o_Code_Err}, 10'd0);
            end
        end
    end

    initial begin
        logic [9:0] exp_cnt;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        u_if.i_Bit_Valid = 1'b0;
        u_if.i_Bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word",    u_if.o_Word,              10'h000);
        chk("rst_valid",   10'(u_if.o_Word_Valid),   10'd0);
        chk("rst_locked",  10'(u_if.o_Locked),       10'd0);
        chk("rst_errcnt",  10'(u_if.o_Err_Count),    10'd0);
        rst = 1'b0;

        // Comma from reset locks on the 10th bit
        push(10'h0FA, 1'b1, 1'b0, 1'b1);
        send_word(10'h0FA);
        drain("t1_drain");
        chk("t1_locked", 10'(u_if.o_Locked), 10'd1);

        // Random prefix, comma, then two data words
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        push(10'h0FA, 1'b1, 1'b0, 1'b1);
        send_word(10'h0FA);
        push(10'h2AA, 1'b0, 1'b0, 1'b1);
        send_word(10'h2AA);
        push(10'h155, 1'b0, 1'b0, 1'b1);
        send_word(10'h155);
        drain("t2_drain");
        chk("t2_hold_word", u_if.o_Word, 10'h155);

        // Four invalid words drop lock on the fourth pulse
        for (int i = 0; i < 4; i++) begin
            push(10'h3FF, 1'b0, 1'b1, (i < 3) ? 1'b1 : 1'b0);
            send_word(10'h3FF);
        end
        drain("t3_drain");
        chk("t3_unlocked", 10'(u_if.o_Locked), 10'd0);
`ifdef COMMA_ALIGNER_ERR_CNT_EN
        exp_cnt = 10'd4;
`else
        exp_cnt = 10'd0;
`endif
        chk("t3_errcnt", 10'(u_if.o_Err_Count), exp_cnt);

        // Relock from the shifted contents, then a valid word breaks the error run
        push(10'h0FA, 1'b1, 1'b0, 1'b1);
        send_word(10'h0FA);
        for (int i = 0; i < 3; i++) begin
            push(10'h000, 1'b0, 1'b1, 1'b1);
            send_word(10'h000);
        end
        push(10'h2AA, 1'b0, 1'b0, 1'b1);
        send_word(10'h2AA);
        for (int i = 0; i < 3; i++) begin
            push(10'h000, 1'b0, 1'b1, 1'b1);
            send_word(10'h000);
        end
        drain("t4_drain");
        chk("t4_locked", 10'(u_if.o_Locked), 10'd1);
`ifdef COMMA_ALIGNER_ERR_CNT_EN
        exp_cnt = 10'd10;
`else
        exp_cnt = 10'd0;
`endif
        chk("t4_errcnt", 10'(u_if.o_Err_Count), exp_cnt);

        // Gapped bit stream
        push(10'h155, 1'b0, 1'b0, 1'b1);
        send_word_toggle(10'h155);
        drain("t5_drain");

        // Reset mid-word (with a valid bit in the reset cycle), then realign
        for (int i = 0; i < 5; i++) send_bit(1'(i % 2));
        rst = 1'b1;
        u_if.i_Bit_Valid = 1'b1;
        u_if.i_Bit = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        u_if.i_Bit_Valid = 1'b0;
        chk("t6_unlocked", 10'(u_if.o_Locked), 10'd0);
        chk("t6_word_clr", u_if.o_Word, 10'h000);
        chk("t6_errcnt",   10'(u_if.o_Err_Count), 10'd0);
        drain("t6_no_pulse");
        push(10'h0FA, 1'b1, 1'b0, 1'b1);
        send_word(10'h0FA);
        push(10'h155, 1'b0, 1'b0, 1'b1);
        send_word(10'h155);
        drain("t6_drain");
        chk("t6_locked", 10'(u_if.o_Locked), 10'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
